// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int FETCH_XLEN  = 32;

  typedef enum logic {
    REDIR_BRANCH = 1'b0,
    REDIR_JALR   = 1'b1
  } redir_mode_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetched {pc, instr} entries with flush
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t din,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, redirect targeting and fetch queue control; FETCH_PERF_EN adds perf counters
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int         W           = 32,
  parameter logic [W-1:0] RESET_PC  = '0,
  parameter int         FETCH_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] imem_addr,
  input  logic [W-1:0] imem_rdata,
  input  logic         redir_valid,
  input  logic         redir_mode,
  input  logic [W-1:0] redir_base,
  input  logic [W-1:0] redir_imm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_instr,
  output logic [W-1:0] out_pc,
  output logic         misalign_err
`ifdef FETCH_PERF_EN
  ,
  output logic [W-1:0] perf_fetch,
  output logic [W-1:0] perf_flush,
  output logic [W-1:0] perf_stall
`endif
);

  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] instr;
  } entry_t;

  logic [W-1:0] pc;
  logic [W-1:0] raw;
  logic [W-1:0] tgt;
  logic [W-1:0] taken;
  logic         misaligned;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  entry_t       din;
  entry_t       head;

  always_comb begin
    raw = redir_base + redir_imm;
    tgt = raw;
    if (redir_mode == REDIR_JALR) tgt[0] = 1'b0;
    misaligned = |tgt[1:0];
    taken      = {tgt[W-1:2], 2'b00};
  end

  // A full queue can still accept when decode drains the head in the same cycle.
  assign pop       = !empty && out_ready;
  assign push      = !redir_valid && (!full || pop);
  assign din       = '{pc: pc, instr: imem_rdata};
  assign imem_addr = pc;
  assign out_valid = !empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else if (redir_valid) begin
      pc <= taken;
      if (misaligned) misalign_err <= 1'b1;
    end else if (push) begin
      pc <= pc + W'(INSTR_BYTES);
    end
  end

  fetch_queue #(
    .DEPTH   (FETCH_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redir_valid),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch <= '0;
      perf_flush <= '0;
      perf_stall <= '0;
    end else begin
      if (push)                         perf_fetch <= perf_fetch + 1'b1;
      if (redir_valid)                  perf_flush <= perf_flush + 1'b1;
      if (!redir_valid && full && !pop) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic        redir_mode;
  logic [31:0] redir_base;
  logic [31:0] redir_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_flush;
  logic [31:0] perf_stall;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  // ROM: word i lives at byte address 4i, tagged so it is distinguishable from an address
  assign imem_rdata = 32'hC000_0000 | (imem_addr >> 2);

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .redir_valid  (redir_valid),
    .redir_mode   (redir_mode),
    .redir_base   (redir_base),
    .redir_imm    (redir_imm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .misalign_err (misalign_err)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch   (perf_fetch),
    .perf_flush   (perf_flush),
    .perf_stall   (perf_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic redirect(input logic mode, input logic [31:0] base, input logic [31:0] imm);
    redir_valid = 1'b1;
    redir_mode  = mode;
    redir_base  = base;
    redir_imm   = imm;
    step();
    redir_valid = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    out_ready   = 1'b0;
    redir_valid = 1'b0;
    redir_mode  = 1'b0;
    redir_base  = '0;
    redir_imm   = '0;
    step();
    step();
    check("rst_valid", out_valid, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_misalign", misalign_err, 0);

    // streaming with decode always ready
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("stream_valid", out_valid, 1);
      check("stream_pc", out_pc, 32'(4 * (i - 1)));
      check("stream_instr", out_instr, 32'hC000_0000 | 32'(i - 1));
    end

    // back-pressure fills the queue, then drains in order
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    check("stall_addr", imem_addr, 32'h10);
    check("stall_valid", out_valid, 1);
    check("stall_head", out_pc, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("drain_pc", out_pc, 32'(4 * i));
      step();
    end
    check("drain_addr", imem_addr, 32'h24);

    // branch redirect with three entries queued
    out_ready = 1'b0;
    do_reset();
    step(); step(); step();
    check("pre_br_addr", imem_addr, 32'hC);
    redirect(1'b0, 32'h20, 32'hFFFF_FFF8);
    check("br_addr", imem_addr, 32'h18);
    check("br_flushed", out_valid, 0);
    step();
    check("br_valid", out_valid, 1);
    check("br_pc", out_pc, 32'h18);
    check("br_instr", out_instr, 32'hC000_0006);
    check("br_misalign", misalign_err, 0);

    // JALR targets: bit 0 dropped silently, bit 1 flags misalignment
    redirect(1'b1, 32'h101, 32'h4);
    check("jalr_addr", imem_addr, 32'h104);
    check("jalr_misalign", misalign_err, 0);
    redirect(1'b1, 32'h102, 32'h0);
    check("jalr_mis_addr", imem_addr, 32'h100);
    check("jalr_mis_flag", misalign_err, 1);
    for (int i = 0; i < 4; i++) step();
    check("full_head", out_pc, 32'h100);
    check("sticky_misalign", misalign_err, 1);

    // redirect while full with a pop: everything gone, no push that cycle
    out_ready = 1'b1;
    redirect(1'b0, 32'hFFFF_FFF0, 32'hC);
    check("rp_flushed", out_valid, 0);
    check("rp_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap_instr", out_instr, 32'hFFFF_FFFF);
    step();
    check("wrap_next_pc", out_pc, 32'h0);
    check("sticky_misalign2", misalign_err, 1);

    // reset mid-stream with a partially filled queue
    out_ready = 1'b0;
    step();
    check("mid_valid_pre", out_valid, 1);
    do_reset();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_misalign", misalign_err, 0);

`ifdef FETCH_PERF_EN
    check("perf_fetch_rst", perf_fetch, 0);
    check("perf_flush_rst", perf_flush, 0);
    check("perf_stall_rst", perf_stall, 0);
    for (int i = 0; i < 6; i++) step();
    redirect(1'b0, 32'h40, 32'h0);
    check("perf_fetch", perf_fetch, 4);
    check("perf_flush", perf_flush, 1);
    check("perf_stall", perf_stall, 2);
    do_reset();
    check("perf_fetch_rst2", perf_fetch, 0);
    check("perf_stall_rst2", perf_stall, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage: successor to the single-PC-register fetch path.
- Owns the PC register and drives the instruction-memory address.
- Buffers fetched {pc, instr} pairs in a FETCH_DEPTH-entry queue with a valid/ready handshake to decode.
- Accepts branch and JALR redirects from execute; a redirect flushes the queue.
- Instruction memory is the existing combinational-read ROM, external to this block.

Parameters:
- W, 32, data/address width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FETCH_DEPTH, 4, queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the rising edge of clk).
- imem_addr  out  W  current PC, sent to the ROM.
- imem_rdata  in  W  ROM data for imem_addr, valid in the same cycle.
- redir_valid  in  1  redirect request.
- redir_mode  in  1  0 = branch (PC-relative), 1 = JALR (register-relative).
- redir_base  in  W  branch: PC of the branch instruction; JALR: rs1 value.
- redir_imm  in  W  sign-extended immediate.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  W  head instruction.
- out_pc  out  W  head PC.
- misalign_err  out  1  sticky flag: a redirect target was misaligned.

Behaviour:
- Reset (rst==0 at a clk edge):
  - PC <= RESET_PC; queue emptied (count 0).
  - misalign_err <= 0; out_valid = 0.
  - Reset mid-operation discards all in-flight entries.
- imem_addr = PC, combinationally.
- Target computation:
  - raw = redir_base + redir_imm, modulo 2^W.
  - mode 1: bit 0 of raw is cleared.
  - If the result has bits [1:0] != 0: misalign_err <= 1 (sticky until reset), and the taken target has [1:0] forced to 0.
- push = !redir_valid && (count < FETCH_DEPTH || pop).
- pop = out_valid && out_ready.
- Each cycle, evaluated in this priority order:
  - redir_valid: PC <= target; queue flushed to count 0; no push.
    - A same-cycle pop counts as accepted by decode; the flush discards the remaining entries.
  - Otherwise, if push: write {PC, imem_rdata} at the tail; PC <= PC + 4, wrapping modulo 2^W.
  - Otherwise: PC holds. This is the stall case: queue full and no pop.
- Full with a simultaneous pop: push and pop both occur and count is unchanged.
- Empty with out_ready high: no pop, nothing changes.
- Latency:
  - An instruction fetched in cycle N is presented at the head no earlier than cycle N+1 (registered queue, no bypass).
  - After a redirect in cycle N: PC = target in N+1; first post-redirect instruction has out_valid in N+2.
- Outputs out_instr and out_pc are driven directly from head-entry registers.
  - Their values are don't-care while out_valid == 0.
  - They are stable while out_valid && !out_ready.
- Queue pointers are log2(FETCH_DEPTH) bits and wrap naturally. count is log2(FETCH_DEPTH)+1 bits.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds three W-bit output ports that wrap on overflow and reset to 0.
  - perf_fetch: increments on each push.
  - perf_flush: increments on each redirect.
  - perf_stall: increments on each cycle with !redir_valid and a full queue without pop.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - redir_mode_e enum {REDIR_BRANCH=1'b0, REDIR_JALR=1'b1}.
  - fetch_entry_t packed struct {pc, instr}.
  - INSTR_BYTES = 4.
- Sub-module fetch_queue:
  - Parametrised synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, head.
- fetch_unit holds the PC, target computation, control and the optional counters. The ROM stays external.

Test Plan:
- Reset then run with out_ready=1 and ROM word i at address 4i → out_pc 0,4,8,… with matching instrs; first out_valid 1 cycle after reset release; one instr per cycle sustained.
- Hold out_ready=0 → count reaches FETCH_DEPTH=4; imem_addr stalls at 0x10; head stays pc 0; release → pcs 0x0,0x4,0x8,0xC,0x10 in order, no loss or duplication.
- Branch redirect in cycle N (base=0x20, imm=-8) with a 3-entry queue → in N+1 PC=0x18 and queue empty; head pc 0x18 valid in N+2.
- JALR redirect (base=0x101, imm=0x4) → target 0x104, misalign_err stays 0. JALR with base=0x102, imm=0 → PC=0x100, misalign_err=1 and held until reset.
- Redirect asserted together with a pop while full → the popped entry is consumed, the rest are flushed, no push that cycle. PC=0xFFFF_FFFC with no redirect → next PC 0x0000_0000.
- rst=0 for one cycle mid-stream with the queue partially full → out_valid=0 next cycle, PC=RESET_PC. Under FETCH_PERF_EN, the counters match the push, redirect and stall-cycle counts, and reset to 0.
